// File: rtl/booth_mul_arbiter_if.sv
// Requester / multiplier / response bundle for booth_mul_arbiter.
// slave is the arbiter side, master is the environment (clients plus booth_mul).
interface booth_mul_arbiter_if #(
   parameter int WORD_LEN = 8,
   parameter int N_REQ    = 4
);
   logic [N_REQ-1:0]          i_req_valid;
   logic [N_REQ*WORD_LEN-1:0] i_req_multiplier;
   logic [N_REQ*WORD_LEN-1:0] i_req_multiplicand;
   logic [N_REQ-1:0]          o_req_ready;
   logic                      i_hold;
   logic [WORD_LEN-1:0]       o_mul_multiplier;
   logic [WORD_LEN-1:0]       o_mul_multiplicand;
   logic [2*WORD_LEN-1:0]     i_mul_result;
   logic [N_REQ-1:0]          o_rsp_valid;
   logic [2*WORD_LEN-1:0]     o_rsp_result;
   logic                      o_busy;

   modport slave (
      input  i_req_valid, i_req_multiplier, i_req_multiplicand, i_hold, i_mul_result,
      output o_req_ready, o_mul_multiplier, o_mul_multiplicand, o_rsp_valid, o_rsp_result,
             o_busy
   );

   modport master (
      output i_req_valid, i_req_multiplier, i_req_multiplicand, i_hold, i_mul_result,
      input  o_req_ready, o_mul_multiplier, o_mul_multiplicand, o_rsp_valid, o_rsp_result,
             o_busy
   );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin sharing of one pipelined booth_mul among N_REQ requesters.
// One pair issued per cycle; an owner tag travels alongside the multiplier
// pipeline so each product is steered back to the requester that issued it.
module booth_mul_arbiter #(
   parameter int WORD_LEN    = 8,
   parameter int N_REQ       = 4,
   parameter int MUL_LATENCY = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   booth_mul_arbiter_if.slave   bus
);
   localparam int             PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [PTR_W:0] N_REQ_W = (PTR_W+1)'(N_REQ);
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_REQ - 1);

   logic [PTR_W-1:0]                    ptr_q, ptr_d;
   logic                                grant_found;
   logic [PTR_W-1:0]                    grant_idx;
   logic [PTR_W:0]                      cand;
   logic                                hs;
   logic [N_REQ-1:0]                    ready;
   logic [WORD_LEN-1:0]                 mplier_q, mcand_q;
   logic [MUL_LATENCY:0]                tag_vld_q;
   logic [MUL_LATENCY:0][PTR_W-1:0]     tag_idx_q;
   logic [N_REQ-1:0]                    rsp_vld_q;
   logic [2*WORD_LEN-1:0]               rsp_res_q;

   // First valid requester at or after ptr, wrapping around
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
         if (cand >= N_REQ_W) cand = cand - N_REQ_W;
         if (!grant_found && bus.i_req_valid[cand[PTR_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[PTR_W-1:0];
         end
      end
   end

   // Grant is suppressed while held or in reset; ready only ever rises on a valid lane
   always_comb begin
      ready = '0;
      hs    = grant_found && !bus.i_hold && !i_rst;
      if (hs) ready[grant_idx] = 1'b1;
   end

   // Pointer moves just past the winner, holds otherwise
   always_comb begin
      ptr_d = ptr_q;
      if (hs) ptr_d = (grant_idx == LAST) ? '0 : grant_idx + PTR_W'(1);
   end

   // Pointer and operand registers feeding the multiplier
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr_q    <= '0;
         mplier_q <= '0;
         mcand_q  <= '0;
      end else begin
         ptr_q <= ptr_d;
         if (hs) begin
            mplier_q <= bus.i_req_multiplier[grant_idx*WORD_LEN +: WORD_LEN];
            mcand_q  <= bus.i_req_multiplicand[grant_idx*WORD_LEN +: WORD_LEN];
         end
      end
   end

   // Owner tags shadow the multiplier pipeline; the tail lines up with i_mul_result
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tag_vld_q <= '0;
         tag_idx_q <= '0;
      end else begin
         tag_vld_q[0] <= hs;
         tag_idx_q[0] <= grant_idx;
         for (int s = 1; s <= MUL_LATENCY; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_idx_q[s] <= tag_idx_q[s-1];
         end
      end
   end

   // Capture the product for the tail owner; result holds between responses
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rsp_vld_q <= '0;
         rsp_res_q <= '0;
      end else if (tag_vld_q[MUL_LATENCY]) begin
         rsp_vld_q <= N_REQ'(1) << tag_idx_q[MUL_LATENCY];
         rsp_res_q <= bus.i_mul_result;
      end else begin
         rsp_vld_q <= '0;
      end
   end

   assign bus.o_req_ready        = ready;
   assign bus.o_mul_multiplier   = mplier_q;
   assign bus.o_mul_multiplicand = mcand_q;
   assign bus.o_rsp_valid        = rsp_vld_q;
   assign bus.o_rsp_result       = rsp_res_q;
   assign bus.o_busy             = (|tag_vld_q) | (|rsp_vld_q);
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a 2-stage behavioural multiplier,
// plus a handshake-correct random soak with an in-order scoreboard.
module tb_booth_mul_arbiter;
   localparam int W = 8, N = 4, LAT = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   booth_mul_arbiter_if #(.WORD_LEN(W), .N_REQ(N)) bus();
   booth_mul_arbiter #(.WORD_LEN(W), .N_REQ(N), .MUL_LATENCY(LAT)) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus)
   );

   // Behavioural booth_mul: two register stages after the operand registers
   logic signed [15:0] ma, mb, m1, m2;
   assign ma = {{8{bus.o_mul_multiplier[7]}}, bus.o_mul_multiplier};
   assign mb = {{8{bus.o_mul_multiplicand[7]}}, bus.o_mul_multiplicand};
   always_ff @(posedge clk) begin
      m1 <= ma * mb;
      m2 <= m1;
   end
   assign bus.i_mul_result = m2;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] p16(input int x);
      return x[15:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_pair(input int r, input logic [7:0] a, input logic [7:0] b);
      bus.i_req_multiplier[r*W +: W]   = a;
      bus.i_req_multiplicand[r*W +: W] = b;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.i_req_valid = '0;
      bus.i_hold = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [7:0] fa [4] = '{8'd3, 8'hFC, 8'd10, 8'hF9};
   logic [7:0] fb [4] = '{8'd5, 8'd6, 8'hF6, 8'hF7};
   int         fp [4] = '{15, -24, -100, 63};
   logic [7:0] xa [3] = '{8'h80, 8'h80, 8'h7F};
   logic [7:0] xb [3] = '{8'h80, 8'h7F, 8'h7F};
   int         xp [3] = '{16384, -16256, 16129};
   logic [3:0] hr [13] = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd8, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
   logic [3:0] hv [13] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd8, 4'd1};
   int         hp [13] = '{0, 0, 0, 0, 15, -24, 0, 0, 0, 0, -100, 63, 15};

   logic [N-1:0] pend;
   logic [7:0]   sa [N], sb [N];
   int           waitc [N];
   int           qr [$], qp [$];
   int           accepted, cyc;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_req_multiplier = '0;
      bus.i_req_multiplicand = '0;

      // Reset state, with all valid high to show reset gates ready
      rst = 1'b1;
      bus.i_hold = 1'b0;
      bus.i_req_valid = '1;
      tick();
      tick();
      settle();
      chk("reset ready", 32'(bus.o_req_ready), 32'd0);
      chk("reset rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
      chk("reset rsp_result", 32'(bus.o_rsp_result), 32'd0);
      chk("reset mul_mplier", 32'(bus.o_mul_multiplier), 32'd0);
      chk("reset mul_mcand", 32'(bus.o_mul_multiplicand), 32'd0);
      chk("reset busy", 32'(bus.o_busy), 32'd0);

      // Single request: r2, 7 * -3
      do_reset();
      set_pair(2, 8'd7, 8'hFD);
      bus.i_req_valid = 4'b0100;
      settle();
      chk("t1 ready c0", 32'(bus.o_req_ready), 32'h4);
      chk("t1 busy c0", 32'(bus.o_busy), 32'd0);
      tick();
      bus.i_req_valid = '0;
      settle();
      chk("t1 mul_mplier c1", 32'(bus.o_mul_multiplier), 32'h07);
      chk("t1 mul_mcand c1", 32'(bus.o_mul_multiplicand), 32'hFD);
      chk("t1 busy c1", 32'(bus.o_busy), 32'd1);
      for (int c = 2; c <= 3; c++) begin
         tick();
         chk($sformatf("t1 busy c%0d", c), 32'(bus.o_busy), 32'd1);
         chk($sformatf("t1 rsp_valid c%0d", c), 32'(bus.o_rsp_valid), 32'd0);
      end
      tick();
      chk("t1 rsp_valid c4", 32'(bus.o_rsp_valid), 32'h4);
      chk("t1 rsp_result c4", 32'(bus.o_rsp_result), 32'(p16(-21)));
      chk("t1 busy c4", 32'(bus.o_busy), 32'd1);
      tick();
      chk("t1 busy c5", 32'(bus.o_busy), 32'd0);
      chk("t1 rsp_valid c5", 32'(bus.o_rsp_valid), 32'd0);
      chk("t1 rsp_result hold c5", 32'(bus.o_rsp_result), 32'(p16(-21)));

      // Fair arbitration: all valid for 6 cycles
      do_reset();
      for (int r = 0; r < N; r++) set_pair(r, fa[r], fb[r]);
      for (int c = 0; c < 10; c++) begin
         bus.i_req_valid = (c < 6) ? 4'hF : 4'h0;
         settle();
         chk($sformatf("t2 ready c%0d", c), 32'(bus.o_req_ready),
             (c < 6) ? 32'(4'b0001 << (c % 4)) : 32'd0);
         if (c >= 4) begin
            chk($sformatf("t2 rsp_valid c%0d", c), 32'(bus.o_rsp_valid), 32'(4'b0001 << ((c - 4) % 4)));
            chk($sformatf("t2 rsp_result c%0d", c), 32'(bus.o_rsp_result), 32'(p16(fp[(c - 4) % 4])));
         end
         tick();
      end

      // Signed extremes back-to-back through r1
      do_reset();
      for (int c = 0; c < 7; c++) begin
         if (c < 3) begin
            set_pair(1, xa[c], xb[c]);
            bus.i_req_valid = 4'b0010;
         end else begin
            bus.i_req_valid = '0;
         end
         settle();
         chk($sformatf("t3 ready c%0d", c), 32'(bus.o_req_ready), (c < 3) ? 32'h2 : 32'h0);
         if (c >= 4) begin
            chk($sformatf("t3 rsp_valid c%0d", c), 32'(bus.o_rsp_valid), 32'h2);
            chk($sformatf("t3 rsp_result c%0d", c), 32'(bus.o_rsp_result), 32'(p16(xp[c - 4])));
         end
         tick();
      end

      // Hold in cycles 2..5 with all valid
      do_reset();
      for (int r = 0; r < N; r++) set_pair(r, fa[r], fb[r]);
      for (int c = 0; c < 13; c++) begin
         bus.i_req_valid = (c <= 8) ? 4'hF : 4'h0;
         bus.i_hold = (c >= 2 && c <= 5);
         settle();
         chk($sformatf("t4 ready c%0d", c), 32'(bus.o_req_ready), 32'(hr[c]));
         chk($sformatf("t4 rsp_valid c%0d", c), 32'(bus.o_rsp_valid), 32'(hv[c]));
         if (hv[c] != 4'd0)
            chk($sformatf("t4 rsp_result c%0d", c), 32'(bus.o_rsp_result), 32'(p16(hp[c])));
         if (c == 6) chk("t4 busy drained c6", 32'(bus.o_busy), 32'd0);
         tick();
      end
      bus.i_hold = 1'b0;

      // Reset mid-flight after grants in cycles 0 and 1
      do_reset();
      bus.i_req_valid = 4'hF;
      settle();
      chk("t5 ready c0", 32'(bus.o_req_ready), 32'h1);
      tick();
      chk("t5 ready c1", 32'(bus.o_req_ready), 32'h2);
      tick();
      rst = 1'b1;
      settle();
      chk("t5 ready in reset c2", 32'(bus.o_req_ready), 32'd0);
      tick();
      rst = 1'b0;
      bus.i_req_valid = '0;
      settle();
      chk("t5 rsp_result c3", 32'(bus.o_rsp_result), 32'd0);
      chk("t5 mul_mplier c3", 32'(bus.o_mul_multiplier), 32'd0);
      chk("t5 mul_mcand c3", 32'(bus.o_mul_multiplicand), 32'd0);
      for (int c = 3; c < 8; c++) begin
         chk($sformatf("t5 rsp_valid c%0d", c), 32'(bus.o_rsp_valid), 32'd0);
         chk($sformatf("t5 busy c%0d", c), 32'(bus.o_busy), 32'd0);
         tick();
      end

      // Random soak: requesters keep valid and operands stable until granted
      do_reset();
      pend = '0;
      accepted = 0;
      cyc = 0;
      for (int r = 0; r < N; r++) waitc[r] = 0;
      while ((accepted < 1000 || qr.size() > 0) && cyc < 20000) begin
         for (int r = 0; r < N; r++) begin
            if (!pend[r] && accepted < 1000 && $urandom_range(0, 2) != 0) begin
               pend[r] = 1'b1;
               sa[r] = 8'($urandom);
               sb[r] = 8'($urandom);
               set_pair(r, sa[r], sb[r]);
            end
         end
         bus.i_req_valid = pend;
         bus.i_hold = ($urandom_range(0, 4) == 0);
         settle();
         if (bus.o_rsp_valid != '0) begin
            if (qr.size() == 0) begin
               chk("soak unexpected rsp", 32'(bus.o_rsp_valid), 32'd0);
            end else begin
               chk("soak rsp owner", 32'(bus.o_rsp_valid), 32'(4'b0001 << qr[0]));
               chk("soak rsp product", 32'(bus.o_rsp_result), 32'(p16(qp[0])));
               void'(qr.pop_front());
               void'(qp.pop_front());
            end
         end
         chk("soak ready onehot0", 32'($onehot0(bus.o_req_ready)), 32'd1);
         for (int r = 0; r < N; r++) begin
            if (bus.o_req_ready[r]) begin
               chk("soak ready on valid", 32'(pend[r]), 32'd1);
               chk("soak fairness", 32'(waitc[r] < N), 32'd1);
               qr.push_back(r);
               qp.push_back(int'($signed(sa[r])) * int'($signed(sb[r])));
               pend[r] = 1'b0;
               waitc[r] = 0;
               accepted++;
            end else if (pend[r] && !bus.i_hold) begin
               waitc[r]++;
            end
         end
         tick();
         cyc++;
      end
      bus.i_req_valid = '0;
      bus.i_hold = 1'b0;
      chk("soak completed in budget", 32'(cyc < 20000), 32'd1);
      chk("soak queue empty", 32'(qr.size()), 32'd0);
      for (int c = 0; c < 6; c++) begin
         settle();
         chk("soak no extra rsp", 32'(bus.o_rsp_valid), 32'd0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
